// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
`default_nettype none

package sram_arb_pkg;

   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DATA_W = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_SETUP  = 3'd1,
      W_STROBE = 3'd2,
      W_HOLD   = 3'd3,
      R_WAIT   = 3'd4,
      R_DONE   = 3'd5
   } state_t;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter.sv
// Arbitrates the single-port SRAM between a write requester and a read requester,
// generating WE_N/OE_N strobes and the data-bus drive enable with a turnaround cycle.
`default_nettype none

module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int WR_CYCLES = 2,
   parameter int RD_WAIT   = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq_out,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq_in,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_ce_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);

   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

   state_t           state;
   state_t           next_state;
   grant_t           last_grant;
   logic [CNT_W-1:0] wait_cnt;
   logic             grant_wr;
   logic             grant_rd;
   logic             cnt_done;
   logic             nx_we_n;
   logic             nx_oe_n;
   logic             nx_dq_oe;
   logic             nx_wr_ack;
   logic             nx_rd_valid;

   assign cnt_done = (wait_cnt == '0);

   always_comb begin
      next_state = state;
      grant_wr   = 1'b0;
      grant_rd   = 1'b0;
      case (state)
         IDLE: begin
            // Under contention the port not served last time wins.
            if (i_wr_req && (!i_rd_req || last_grant == GRANT_RD)) begin
               next_state = W_SETUP;
               grant_wr   = 1'b1;
            end else if (i_rd_req) begin
               next_state = R_WAIT;
               grant_rd   = 1'b1;
            end
         end
         W_SETUP:  next_state = W_STROBE;
         W_STROBE: if (cnt_done) next_state = W_HOLD;
         W_HOLD:   next_state = IDLE;
         R_WAIT:   if (cnt_done) next_state = R_DONE;
         R_DONE:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase

      // Pin controls are decoded from the next state and registered, so the
      // SRAM strobes come straight off flops.
      nx_we_n     = (next_state != W_STROBE);
      nx_oe_n     = !(next_state == R_WAIT || next_state == R_DONE);
      nx_dq_oe    = (next_state == W_SETUP || next_state == W_STROBE || next_state == W_HOLD);
      nx_wr_ack   = (next_state == W_HOLD);
      nx_rd_valid = (next_state == R_DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_grant    <= GRANT_RD;
         wait_cnt      <= '0;
         o_wr_ack      <= 1'b0;
         o_rd_valid    <= 1'b0;
         o_rd_data     <= '0;
         o_sram_addr   <= '0;
         o_sram_dq_out <= '0;
         o_sram_dq_oe  <= 1'b0;
         o_sram_we_n   <= 1'b1;
         o_sram_oe_n   <= 1'b1;
      end else begin
         o_sram_we_n  <= nx_we_n;
         o_sram_oe_n  <= nx_oe_n;
         o_sram_dq_oe <= nx_dq_oe;
         o_wr_ack     <= nx_wr_ack;
         o_rd_valid   <= nx_rd_valid;

         if (grant_wr) begin
            o_sram_addr   <= i_wr_addr;
            o_sram_dq_out <= i_wr_data;
            last_grant    <= GRANT_WR;
         end
         if (grant_rd) begin
            o_sram_addr <= i_rd_addr;
            last_grant  <= GRANT_RD;
            wait_cnt    <= RD_LOAD;
         end

         if (state == W_SETUP) begin
            wait_cnt <= WR_LOAD;
         end else if ((state == W_STROBE || state == R_WAIT) && !cnt_done) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         if (state == R_WAIT && cnt_done) begin
            o_rd_data <= i_sram_dq_in;
         end
      end
   end

   assign o_sram_ce_n = 1'b0;
   assign o_sram_lb_n = 1'b0;
   assign o_sram_ub_n = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: drivers queue expected completions, a
// negedge monitor pops them and also watches strobe timing and bus turnaround.
`default_nettype none

module tb_sram_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int WR = 2;
   localparam int RD = 2;

   logic          clk;
   logic          rst;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] dq_out;
   logic          dq_oe;
   logic [DW-1:0] dq_in;
   logic          we_n;
   logic          oe_n;
   logic          ce_n;
   logic          lb_n;
   logic          ub_n;

   sram_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .WR_CYCLES(WR),
      .RD_WAIT  (RD)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_wr_req     (wr_req),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .o_wr_ack     (wr_ack),
      .i_rd_req     (rd_req),
      .i_rd_addr    (rd_addr),
      .o_rd_valid   (rd_valid),
      .o_rd_data    (rd_data),
      .o_sram_addr  (sram_addr),
      .o_sram_dq_out(dq_out),
      .o_sram_dq_oe (dq_oe),
      .i_sram_dq_in (dq_in),
      .o_sram_we_n  (we_n),
      .o_sram_oe_n  (oe_n),
      .o_sram_ce_n  (ce_n),
      .o_sram_lb_n  (lb_n),
      .o_sram_ub_n  (ub_n)
   );

   typedef struct {
      bit            is_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            issue;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mem[logic [AW-1:0]];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // SRAM model: writes land while WE_N is low, reads present data while OE_N is low.
   always @(negedge clk) begin
      if (!rst && !we_n && dq_oe) mem[sram_addr] = dq_out;
   end
   always @(negedge clk) begin
      if (!oe_n && mem.exists(sram_addr)) dq_in = mem[sram_addr];
      else dq_in = 16'hDEAD;
   end

   // Monitor
   int we_cnt, dqoe_cnt, oel_cnt;
   bit expect_idle;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         we_cnt = 0; dqoe_cnt = 0; oel_cnt = 0; expect_idle = 0;
      end else begin
         if (dq_oe) dqoe_cnt++;
         if (!we_n) we_cnt++;
         if (!oe_n) oel_cnt++;
         if (dq_oe || !oe_n) check("bus_conflict", {31'b0, dq_oe & ~oe_n}, 32'd0);
         if (expect_idle) begin
            check("idle_gap", {29'b0, dq_oe, oe_n, we_n}, 32'd3);
            expect_idle = 0;
         end
         if (wr_ack || rd_valid) begin
            check("single_event", {31'b0, wr_ack & rd_valid}, 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_event", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("order_is_rd", {31'b0, rd_valid}, {31'b0, e.is_rd});
               check("sram_addr", {12'b0, sram_addr}, {12'b0, e.addr});
               if (e.is_rd) begin
                  check("rd_data", {16'b0, rd_data}, {16'b0, e.data});
                  check("rd_oe_low_cycles", oel_cnt, RD + 1);
                  check("rd_dq_oe_cycles", dqoe_cnt, 0);
               end else begin
                  check("wr_we_low_cycles", we_cnt, WR);
                  check("wr_dq_oe_cycles", dqoe_cnt, WR + 2);
                  check("wr_oe_low_cycles", oel_cnt, 0);
                  check("wr_mem_data", {16'b0, mem.exists(e.addr) ? mem[e.addr] : 16'hxxxx},
                        {16'b0, e.data});
               end
               if (e.lat >= 0) check("latency", cyc - e.issue, e.lat);
            end
            we_cnt = 0; dqoe_cnt = 0; oel_cnt = 0; expect_idle = 1;
         end
      end
   end

   task automatic wait_evt(input bit rd, output bit got);
      got = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rd ? rd_valid : wr_ack) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit push, input bit timed);
      exp_t e;
      bit   got;
      @(posedge clk); #1;
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      if (push) begin
         e.is_rd = 0; e.addr = a; e.data = d; e.issue = cyc; e.lat = timed ? WR + 2 : -1;
         sb.push_back(e);
      end
      if (timed) begin
         // Grant is already past here; changed inputs must not reach the SRAM.
         @(negedge clk); @(negedge clk);
         wr_addr = ~a; wr_data = ~d;
      end
      wait_evt(0, got);
      check("wr_done", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
      wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit push, input bit timed, input bit after_wr);
      exp_t e;
      bit   got;
      if (after_wr) begin
         wait_evt(0, got);
         check("rd_after_wr_ack", {31'b0, got}, 32'd1);
      end
      @(posedge clk); #1;
      rd_addr = a; rd_req = 1'b1;
      if (push) begin
         e.is_rd = 1; e.addr = a; e.data = d; e.issue = cyc; e.lat = timed ? RD + 1 : -1;
         sb.push_back(e);
      end
      if (timed) begin
         @(negedge clk); @(negedge clk);
         rd_addr = ~a;
      end
      wait_evt(1, got);
      check("rd_done", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic push_exp(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.is_rd = is_rd; e.addr = a; e.data = d; e.issue = 0; e.lat = -1;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      rst = 1'b1; wr_req = 0; rd_req = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      dq_in = '0;
      mem[20'h00030] = 16'hC0DE;
      repeat (2) @(negedge clk);
      check("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
      check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_rd_data", {16'b0, rd_data}, 32'd0);
      check("rst_sram_addr", {12'b0, sram_addr}, 32'd0);
      check("rst_dq_out", {16'b0, dq_out}, 32'd0);
      check("rst_dq_oe", {31'b0, dq_oe}, 32'd0);
      check("rst_we_n", {31'b0, we_n}, 32'd1);
      check("rst_oe_n", {31'b0, oe_n}, 32'd1);
      check("rst_ce_lb_ub", {29'b0, ce_n, lb_n, ub_n}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Contention after reset: write wins, then read; a second round alternates again.
      push_exp(0, 20'h00100, 16'h1111);
      push_exp(1, 20'h00100, 16'h1111);
      fork
         do_write(20'h00100, 16'h1111, 0, 0);
         do_read(20'h00100, 16'h1111, 0, 0, 0);
      join
      push_exp(0, 20'h00200, 16'h2222);
      push_exp(1, 20'h00200, 16'h2222);
      fork
         do_write(20'h00200, 16'h2222, 0, 0);
         do_read(20'h00200, 16'h2222, 0, 0, 0);
      join

      do_write(20'h00010, 16'hBEEF, 1, 1);
      do_read(20'h00010, 16'hBEEF, 1, 1, 0);
      do_read(20'h00030, 16'hC0DE, 1, 1, 0);

      // Read requested on the very edge the write completes.
      fork
         do_write(20'h00020, 16'h1234, 1, 1);
         do_read(20'h00020, 16'h1234, 1, 1, 1);
      join

      // Reset while WE_N is low: strobes drop at once, the write restarts afterwards.
      wr_addr = 20'h00040; wr_data = 16'h7777;
      @(posedge clk); #1 wr_req = 1'b1;
      got = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!we_n) begin got = 1; break; end
      end
      check("reach_strobe", {31'b0, got}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_we_n", {31'b0, we_n}, 32'd1);
      check("async_rst_dq_oe", {31'b0, dq_oe}, 32'd0);
      check("async_rst_wr_ack", {31'b0, wr_ack}, 32'd0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      begin
         exp_t e;
         e.is_rd = 0; e.addr = 20'h00040; e.data = 16'h7777; e.issue = cyc; e.lat = WR + 2;
         sb.push_back(e);
      end
      wait_evt(0, got);
      check("wr_after_rst", {31'b0, got}, 32'd1);
      @(posedge clk); #1 wr_req = 1'b0;

      // Address extremes.
      do_write(20'hFFFFF, 16'hA5A5, 1, 1);
      do_write(20'h00000, 16'h5A5A, 1, 1);
      do_read(20'hFFFFF, 16'hA5A5, 1, 1, 0);
      do_read(20'h00000, 16'h5A5A, 1, 1, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
